// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Results that do not fit in DIGITS decimal digits are shown as all-'E' with overflow set.
module bin_to_bcd_seq #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   function automatic logic [63:0] max_val();
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < DIGITS; i++) p = p * 64'd10;
      return p - 64'd1;
   endfunction

   localparam logic [63:0] MAX_VAL = max_val();

   // Add 3 to every nibble >= 5; nibbles never exceed 9 here, so no inter-nibble carry.
   function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] s);
      logic [BW-1:0] r;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t             state_q,    state_d;
   logic [WIDTH-1:0]   shreg_q,    shreg_d;
   logic [BW-1:0]      scratch_q,  scratch_d;
   logic [CW-1:0]      cnt_q,      cnt_d;
   logic               ovf_pend_q, ovf_pend_d;
   logic [BW-1:0]      bcd_out_q,  bcd_out_d;
   logic               overflow_q, overflow_d;
   logic               done_q,     done_d;
   logic [BW-1:0]      adj;
   logic               too_big;

   assign too_big = (64'(bin_in) > MAX_VAL);
   assign adj     = dabble_adj(scratch_q);

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      bcd_out_d  = bcd_out_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (too_big) begin
                  scratch_d  = {DIGITS{4'hE}};
                  ovf_pend_d = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  shreg_d    = bin_in;
                  scratch_d  = '0;
                  cnt_d      = '0;
                  ovf_pend_d = 1'b0;
                  state_d    = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            {scratch_d, shreg_d} = {adj[BW-2:0], shreg_q, 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
         end
         S_DONE: begin
            // Outputs move only here so the display never sees partial digits.
            bcd_out_d  = scratch_q;
            overflow_d = ovf_pend_q;
            done_d     = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         shreg_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         bcd_out_q  <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         bcd_out_q  <= bcd_out_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign bcd_out  = bcd_out_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: latency, digit values, overflow, ignored starts,
// abort by reset and back-to-back conversions.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] bin_in = '0;
   logic        busy;
   logic        done;
   logic [31:0] bcd_out;
   logic        overflow;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int lat;
   int d0;

   bin_to_bcd_seq #(.WIDTH(32), .DIGITS(8)) dut (
      .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
      .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Ticks until done is seen, bounded; n is the number of ticks taken.
   task automatic wait_done(input int max, output int n);
      n = 0;
      while (done !== 1'b1 && n < max) begin
         tick();
         n++;
      end
   endtask

   task automatic run_conv(input logic [31:0] val, output int n);
      start  = 1'b1;
      bin_in = val;
      tick();
      start  = 1'b0;
      wait_done(100, n);
   endtask

   initial begin
      // Reset state
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd", bcd_out, 32'h0);
      chk("rst_ovf", 32'(overflow), 32'd0);

      // Test 1: zero, with latency and busy window
      start = 1'b1; bin_in = 32'd0;
      tick();
      start = 1'b0;
      chk("t1_busy_e0", 32'(busy), 32'd1);
      for (int i = 1; i < 32; i++) tick();
      chk("t1_busy_e31", 32'(busy), 32'd1);
      chk("t1_nodone_e31", 32'(done), 32'd0);
      tick();
      chk("t1_busy_e32", 32'(busy), 32'd1);
      chk("t1_nodone_e32", 32'(done), 32'd0);
      tick();
      chk("t1_done_e33", 32'(done), 32'd1);
      chk("t1_idle_e33", 32'(busy), 32'd0);
      chk("t1_bcd", bcd_out, 32'h0000_0000);
      chk("t1_ovf", 32'(overflow), 32'd0);
      tick();
      chk("t1_done_clr", 32'(done), 32'd0);

      // Test 2: mixed digits
      run_conv(32'd12_345_678, lat);
      chk("t2_lat", 32'(lat), 32'd33);
      chk("t2_bcd", bcd_out, 32'h1234_5678);
      chk("t2_ovf", 32'(overflow), 32'd0);
      tick();

      // Test 3: largest displayable, then just past it, then all ones
      run_conv(32'd99_999_999, lat);
      chk("t3_max_lat", 32'(lat), 32'd33);
      chk("t3_max_bcd", bcd_out, 32'h9999_9999);
      chk("t3_max_ovf", 32'(overflow), 32'd0);
      tick();
      run_conv(32'd100_000_000, lat);
      chk("t3_ovf_lat", 32'(lat), 32'd1);
      chk("t3_ovf_bcd", bcd_out, 32'hEEEE_EEEE);
      chk("t3_ovf_flag", 32'(overflow), 32'd1);
      tick();
      chk("t3_ovf_done_clr", 32'(done), 32'd0);
      chk("t3_ovf_hold", 32'(overflow), 32'd1);
      chk("t3_ovf_bcd_hold", bcd_out, 32'hEEEE_EEEE);
      run_conv(32'hFFFF_FFFF, lat);
      chk("t3_ffff_lat", 32'(lat), 32'd1);
      chk("t3_ffff_bcd", bcd_out, 32'hEEEE_EEEE);
      tick();

      // Test 4: start while busy is ignored
      d0 = done_cnt;
      start = 1'b1; bin_in = 32'd4321;
      tick();
      start = 1'b0;
      for (int i = 1; i < 5; i++) tick();
      start = 1'b1; bin_in = 32'd9999;
      tick();
      start = 1'b0;
      chk("t4_busy_e5", 32'(busy), 32'd1);
      chk("t4_bcd_held", bcd_out, 32'hEEEE_EEEE);
      wait_done(100, lat);
      chk("t4_lat", 32'(lat), 32'd28);
      chk("t4_bcd", bcd_out, 32'h0000_4321);
      chk("t4_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 40; i++) tick();
      chk("t4_one_done", 32'(done_cnt - d0), 32'd1);
      chk("t4_bcd_after", bcd_out, 32'h0000_4321);

      // Test 5: reset aborts a conversion
      start = 1'b1; bin_in = 32'd5555;
      tick();
      start = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      d0 = done_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_bcd", bcd_out, 32'h0);
      chk("t5_done", 32'(done), 32'd0);
      for (int i = 0; i < 40; i++) tick();
      chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
      run_conv(32'd7, lat);
      chk("t5_lat", 32'(lat), 32'd33);
      chk("t5_bcd7", bcd_out, 32'h0000_0007);

      // Test 6: back-to-back, new start in the done cycle
      tick();
      run_conv(32'd42, lat);
      chk("t6_lat1", 32'(lat), 32'd33);
      chk("t6_bcd1", bcd_out, 32'h0000_0042);
      start = 1'b1; bin_in = 32'd1000;
      tick();
      start = 1'b0;
      chk("t6_busy", 32'(busy), 32'd1);
      chk("t6_done_clr", 32'(done), 32'd0);
      for (int i = 1; i < 32; i++) tick();
      chk("t6_bcd_hold", bcd_out, 32'h0000_0042);
      wait_done(100, lat);
      chk("t6_lat2", 32'(lat), 32'd2);
      chk("t6_bcd2", bcd_out, 32'h0000_1000);
      chk("t6_ovf", 32'(overflow), 32'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
